// File: rtl/data_ram_ctrl.sv
// ---------------------------------------------------------------------------
// data_ram_ctrl
//
// Data-memory responder behind the MEM-stage load/store port. A request is
// captured in IDLE, held for WAIT_CYCLES wait states, then performed. It
// completes with a one-cycle ack_o, plus err_o when the address is out of
// range. While a request is outstanding, stallreq_o holds the pipeline so
// the MEM stage keeps its request steady until the ack.
//
// Parameters
//   ADDR_W      word-address width; storage is 2**ADDR_W x 32-bit words
//   WAIT_CYCLES wait states between acceptance and completion (0..15)
//
// Ports
//   clk         clock, rising edge
//   rst         synchronous active-high reset (storage is not cleared)
//   mem_ce_i    request valid
//   mem_we_i    1 = store, 0 = load
//   mem_addr_i  byte address; word index = [ADDR_W+1:2], [1:0] ignored
//   mem_sel_i   byte lanes, sel[3] -> data[31:24] ... sel[0] -> data[7:0]
//   mem_data_i  lane-aligned store data
//   mem_data_o  registered read word; 0 after a store completes
//   ack_o       one-cycle completion pulse
//   err_o       one-cycle out-of-range pulse, concurrent with ack_o
//   stallreq_o  stall request = mem_ce_i && state != DONE
// ---------------------------------------------------------------------------
module data_ram_ctrl #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_ce_i,
  input  logic        mem_we_i,
  input  logic [31:0] mem_addr_i,
  input  logic [3:0]  mem_sel_i,
  input  logic [31:0] mem_data_i,
  output logic [31:0] mem_data_o,
  output logic        ack_o,
  output logic        err_o,
  output logic        stallreq_o
);

  localparam int         DEPTH     = 1 << ADDR_W;
  localparam int         HI_SHIFT  = ADDR_W + 2;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);
  localparam bit         ZERO_WAIT = (WAIT_CYCLES == 0);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } state_t;

  state_t      state;
  logic [3:0]  cnt;

  // Captured request; the live port inputs are ignored after acceptance.
  logic        req_we;
  logic [31:0] req_addr;
  logic [3:0]  req_sel;
  logic [31:0] req_data;

  logic [31:0] mem [0:DEPTH-1];

  // Fields of the access performed at this edge. In IDLE they come straight
  // from the port, which only matters for the zero-wait configuration where
  // the access happens on the same edge that accepts the request.
  logic              acc_we;
  logic [31:0]       acc_addr;
  logic [3:0]        acc_sel;
  logic [31:0]       acc_data;
  logic [ADDR_W-1:0] acc_idx;
  logic              acc_oor;
  logic              go;
  logic              do_write;

  always_comb begin
    acc_we   = req_we;
    acc_addr = req_addr;
    acc_sel  = req_sel;
    acc_data = req_data;
    if (state == IDLE) begin
      acc_we   = mem_we_i;
      acc_addr = mem_addr_i;
      acc_sel  = mem_sel_i;
      acc_data = mem_data_i;
    end
  end

  assign acc_idx = acc_addr[ADDR_W+1:2];
  // Any set bit above the word index means the address is out of range.
  assign acc_oor = (acc_addr >> HI_SHIFT) != 32'd0;

  // The access is performed on the edge that moves the FSM into DONE. A
  // dropped mem_ce_i in WAIT (flush) takes priority, and reset suppresses the
  // write even on the completing edge.
  always_comb begin
    go = 1'b0;
    if (!rst && mem_ce_i) begin
      if (state == IDLE && ZERO_WAIT)           go = 1'b1;
      else if (state == WAIT && cnt == 4'd1)    go = 1'b1;
    end
  end

  assign do_write = go && acc_we && !acc_oor;

  // Storage: byte-lane writes, no reset. An all-zero sel writes nothing.
  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int b = 0; b < 4; b++) begin
        if (acc_sel[b]) mem[acc_idx][8*b +: 8] <= acc_data[8*b +: 8];
      end
    end
  end

  // Control FSM with registered ack/err/read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      mem_data_o <= 32'd0;
      ack_o      <= 1'b0;
      err_o      <= 1'b0;
      req_we     <= 1'b0;
      req_addr   <= 32'd0;
      req_sel    <= 4'd0;
      req_data   <= 32'd0;
    end else begin
      ack_o <= 1'b0;
      err_o <= 1'b0;

      // Completion: ack plus read word (0 for stores and out-of-range loads).
      if (go) begin
        ack_o      <= 1'b1;
        err_o      <= acc_oor;
        mem_data_o <= (acc_we || acc_oor) ? 32'd0 : mem[acc_idx];
      end

      case (state)
        IDLE: begin
          if (mem_ce_i) begin
            req_we   <= mem_we_i;
            req_addr <= mem_addr_i;
            req_sel  <= mem_sel_i;
            req_data <= mem_data_i;
            cnt      <= WAIT_INIT;
            state    <= ZERO_WAIT ? DONE : WAIT;
          end
        end
        WAIT: begin
          if (!mem_ce_i) begin
            // Pipeline flush: drop the request silently.
            state <= IDLE;
            cnt   <= 4'd0;
          end else begin
            cnt <= cnt - 4'd1;
            if (cnt == 4'd1) state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Combinational so the request cycle itself is stalled; released in the
  // ack cycle so the pipeline advances there.
  assign stallreq_o = mem_ce_i && (state != DONE);

endmodule

// File: tb/tb_data_ram_ctrl.sv
// ---------------------------------------------------------------------------
// tb_data_ram_ctrl
//
// Directed bench for data_ram_ctrl. Two instances: u_w2 (WAIT_CYCLES=2) and
// u_w0 (WAIT_CYCLES=0). They share the request fields and reset, but each
// has its own chip enable, so only one is active at a time. Expected values
// are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_data_ram_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce2, ce0;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  sel;
  logic [31:0] wdata;

  logic [31:0] rd2, rd0;
  logic        ack2, ack0, err2, err0, stall2, stall0;

  int n_tests = 0;
  int n_fail  = 0;

  // Selects which instance the access task drives and observes.
  logic        use_z = 1'b0;
  logic [31:0] rd_m;
  logic        ack_m, err_m, stall_m;
  assign rd_m    = use_z ? rd0    : rd2;
  assign ack_m   = use_z ? ack0   : ack2;
  assign err_m   = use_z ? err0   : err2;
  assign stall_m = use_z ? stall0 : stall2;

  always #5 clk = ~clk;

  data_ram_ctrl #(.ADDR_W(10), .WAIT_CYCLES(2)) u_w2 (
    .clk(clk), .rst(rst), .mem_ce_i(ce2), .mem_we_i(we), .mem_addr_i(addr),
    .mem_sel_i(sel), .mem_data_i(wdata), .mem_data_o(rd2), .ack_o(ack2),
    .err_o(err2), .stallreq_o(stall2)
  );

  data_ram_ctrl #(.ADDR_W(10), .WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .rst(rst), .mem_ce_i(ce0), .mem_we_i(we), .mem_addr_i(addr),
    .mem_sel_i(sel), .mem_data_i(wdata), .mem_data_o(rd0), .ack_o(ack0),
    .err_o(err0), .stallreq_o(stall0)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One complete access, starting in an IDLE cycle. Checks stall and ack on
  // every cycle, then the ack cycle's err/data, then the IDLE gap cycle. For
  // wait states, the port fields are scrambled after acceptance so a missing
  // capture shows up in the result.
  task automatic access(input bit z, input bit w, input logic [31:0] a,
                        input logic [3:0] s, input logic [31:0] d,
                        input logic [31:0] exp_rd, input bit exp_err,
                        input string tag);
    int nw;
    nw    = z ? 0 : 2;
    use_z = z;
    we    = w;
    addr  = a;
    sel   = s;
    wdata = d;
    if (z) ce0 = 1'b1; else ce2 = 1'b1;
    #1;
    check({tag, "/req_stall"}, 32'(stall_m), 32'd1);
    check({tag, "/req_ack"},   32'(ack_m),   32'd0);
    for (int k = 0; k < nw; k++) begin
      step();
      if (k == 0) begin
        addr  = 32'hFFFF_FFF0;
        wdata = ~d;
        sel   = ~s;
      end
      check({tag, "/wait_stall"}, 32'(stall_m), 32'd1);
      check({tag, "/wait_ack"},   32'(ack_m),   32'd0);
    end
    step();
    check({tag, "/ack"},       32'(ack_m),   32'd1);
    check({tag, "/err"},       32'(err_m),   32'(exp_err));
    check({tag, "/ack_stall"}, 32'(stall_m), 32'd0);
    check({tag, "/rdata"},     rd_m,         exp_rd);
    ce0 = 1'b0;
    ce2 = 1'b0;
    step();
    check({tag, "/gap_ack"},   32'(ack_m), 32'd0);
    check({tag, "/gap_err"},   32'(err_m), 32'd0);
    check({tag, "/gap_rdata"}, rd_m,       exp_rd);
  endtask

  initial begin
    rst = 1'b1; ce2 = 1'b0; ce0 = 1'b0; we = 1'b0;
    addr = 32'd0; sel = 4'd0; wdata = 32'd0;
    repeat (3) step();
    check("rst/ack2",   32'(ack2),   32'd0);
    check("rst/err2",   32'(err2),   32'd0);
    check("rst/rd2",    rd2,         32'd0);
    check("rst/stall2", 32'(stall2), 32'd0);
    check("rst/ack0",   32'(ack0),   32'd0);
    check("rst/rd0",    rd0,         32'd0);
    ce2 = 1'b1; #1;
    check("rst/stall_follows_ce", 32'(stall2), 32'd1);
    ce2 = 1'b0;
    rst = 1'b0;
    step();

    // Word store / load.
    access(0, 1, 32'h0000_0010, 4'b1111, 32'hDEAD_BEEF, 32'h0, 0, "w_st");
    access(0, 0, 32'h0000_0010, 4'b1111, 32'h0,         32'hDEAD_BEEF, 0, "w_ld");

    // Byte lanes.
    access(0, 1, 32'h0000_0020, 4'b1111, 32'h1122_3344, 32'h0, 0, "bl_init");
    access(0, 1, 32'h0000_0020, 4'b0010, 32'h0000_AB00, 32'h0, 0, "bl_st1");
    access(0, 0, 32'h0000_0020, 4'b1111, 32'h0,         32'h1122_AB44, 0, "bl_ld1");
    access(0, 1, 32'h0000_0020, 4'b1000, 32'hCD00_0000, 32'h0, 0, "bl_st3");
    access(0, 0, 32'h0000_0020, 4'b1111, 32'h0,         32'hCD22_AB44, 0, "bl_ld3");

    // Range error: 0x1000 aliases word 0 if the check were missing.
    access(0, 1, 32'h0000_0000, 4'b1111, 32'hA5A5_A5A5, 32'h0, 0, "rg_init");
    access(0, 1, 32'h0000_1000, 4'b1111, 32'h1234_5678, 32'h0, 1, "rg_st");
    access(0, 0, 32'h0000_1000, 4'b1111, 32'h0,         32'h0, 1, "rg_ld");
    access(0, 0, 32'h0000_0000, 4'b1111, 32'h0,         32'hA5A5_A5A5, 0, "rg_ld0");

    // Abort: drop ce in the first WAIT cycle of a store.
    access(0, 1, 32'h0000_0040, 4'b1111, 32'h0BAD_F00D, 32'h0, 0, "ab_init");
    access(0, 0, 32'h0000_0040, 4'b1111, 32'h0,         32'h0BAD_F00D, 0, "ab_pre");
    use_z = 1'b0; we = 1'b1; addr = 32'h0000_0040; sel = 4'b1111;
    wdata = 32'h5555_5555; ce2 = 1'b1;
    step();
    ce2 = 1'b0;
    step();
    check("ab/ack",   32'(ack2), 32'd0);
    check("ab/rdata", rd2,       32'h0BAD_F00D);
    // Starts immediately: its exact ack timing shows the FSM is back in IDLE.
    access(0, 0, 32'h0000_0040, 4'b1111, 32'h0, 32'h0BAD_F00D, 0, "ab_ld");

    // Reset on the completing edge of a store: store dropped, outputs cleared.
    we = 1'b1; addr = 32'h0000_0040; sel = 4'b1111; wdata = 32'h7777_7777;
    ce2 = 1'b1;
    step();
    step();
    rst = 1'b1;
    step();
    check("rm/ack",   32'(ack2), 32'd0);
    check("rm/err",   32'(err2), 32'd0);
    check("rm/rdata", rd2,       32'd0);
    rst = 1'b0;
    ce2 = 1'b0;
    step();
    access(0, 0, 32'h0000_0040, 4'b1111, 32'h0, 32'h0BAD_F00D, 0, "rm_ld1");
    access(0, 0, 32'h0000_0010, 4'b1111, 32'h0, 32'hDEAD_BEEF, 0, "rm_ld2");

    // Zero wait states.
    access(1, 1, 32'h0000_0008, 4'b1111, 32'h89AB_CDEF, 32'h0, 0, "z_st");
    access(1, 0, 32'h0000_0008, 4'b1111, 32'h0,         32'h89AB_CDEF, 0, "z_ld");
    access(1, 1, 32'h0000_0008, 4'b0000, 32'hFFFF_FFFF, 32'h0, 0, "z_sel0");
    access(1, 0, 32'h0000_0008, 4'b1111, 32'h0,         32'h89AB_CDEF, 0, "z_ld2");
    access(1, 0, 32'h8000_0008, 4'b1111, 32'h0,         32'h0, 1, "z_oor");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/data_ram_ctrl.md
# data_ram_ctrl

Data-memory responder on the far end of the MEM-stage load/store port. It accepts requests from the MEM stage: chip enable, write enable, byte address, 4-bit big-endian byte select and store data. It completes each request after a programmable number of wait states and returns full read words plus a one-cycle acknowledge. While a request is outstanding it raises a stall request to the pipeline controller, so the MEM stage holds its request steady until the acknowledge.

## Interface
Parameters:
- ADDR_W, 10: word-address width; storage depth is 2^ADDR_W 32-bit words.
- WAIT_CYCLES, 2: wait states between acceptance and completion; legal range 0..15.

Ports:
- clk, input, 1: clock; all state changes on the rising edge.
- rst, input, 1: reset, synchronous, active-high.
- mem_ce_i, input, 1: request valid (chip enable).
- mem_we_i, input, 1: 1 = store, 0 = load.
- mem_addr_i, input, 32: byte address; bits [1:0] are ignored, word index = [ADDR_W+1:2].
- mem_sel_i, input, 4: byte lanes; sel[3] = data[31:24] … sel[0] = data[7:0].
- mem_data_i, input, 32: store data, already lane-aligned by the MEM stage.
- mem_data_o, output, 32: registered read word (full word; the MEM stage extracts bytes/halves).
- ack_o, output, 1: one-cycle completion pulse.
- err_o, output, 1: one-cycle pulse concurrent with ack_o for an out-of-range address.
- stallreq_o, output, 1: pipeline stall request.

## Operation
- FSM states: IDLE, WAIT, DONE.
- **IDLE**
  - mem_ce_i=1: capture addr/we/sel/data.
  - Load cnt=WAIT_CYCLES.
  - Next state is WAIT, or DONE if WAIT_CYCLES=0.
- **WAIT**
  - cnt decrements each cycle.
  - On the cycle cnt==1, the next state is DONE and the access is performed.
  - A store writes only the lanes with sel bit=1 into the addressed word.
  - A load latches the full word into mem_data_o.
- **DONE**
  - ack_o=1 for exactly one cycle; next state is IDLE unconditionally.
  - A new request is accepted only in IDLE, so back-to-back requests have one IDLE cycle between them.
- **Range check:** mem_addr_i[31:ADDR_W+2] ≠ 0 makes the request out of range.
  - The store is suppressed.
  - A load returns 0x00000000.
  - err_o=1 together with ack_o.
- **Store with sel=4'b0000:** completes with ack_o, writes nothing, err_o=0.
- **Abort:** mem_ce_i falling to 0 while in WAIT (pipeline flush) returns the FSM to IDLE next cycle. No write, no ack_o, and mem_data_o is unchanged.
- **Captured request:** once captured, changes on the address/data inputs are ignored until DONE.
- **mem_data_o**
  - Updates only on load completion.
  - Set to 0 on store completion.
  - Holds its value otherwise.
- **stallreq_o** = mem_ce_i && (state ≠ DONE). This is combinational, so the request cycle itself is stalled.
- **Storage:** not cleared by rst; contents are undefined until written.

## Timing
- Reset values: state=IDLE, cnt=0, mem_data_o=0, ack_o=0, err_o=0. stallreq_o follows mem_ce_i.
- Request presented in cycle T (state IDLE): ack_o is high in cycle T+1+WAIT_CYCLES.
  - For WAIT_CYCLES=0, ack_o is high in T+1.
- Total stall cycles per access = WAIT_CYCLES+1; the pipeline advances on the ack cycle.
- Read data is valid on mem_data_o in the ack cycle and stays valid afterwards until the next completion.
- A store becomes visible to a load accepted in any later cycle.
- rst asserted mid-request: the next cycle is IDLE with outputs at their reset values. A pending store is dropped, because the write happens only at the WAIT→DONE edge.
- rst in the same cycle as a WAIT→DONE transition: reset wins and no write occurs.

## Test plan
- **Word store/load:** WAIT_CYCLES=2.
  - Store 0xDEADBEEF to 0x00000010, sel=1111 → ack_o in T+3, stallreq_o high T..T+2.
  - Load 0x00000010 → mem_data_o=0xDEADBEEF in its ack cycle.
- **Byte lanes:**
  - Store 0x0000AB00 sel=0010 over 0x11223344 at 0x20; load → 0x1122AB44.
  - Store 0xCD000000 sel=1000; load → 0xCD22AB44.
- **Range error:** with ADDR_W=10, store to 0x00001000.
  - ack_o=1 and err_o=1; no write occurs.
  - A subsequent load of 0x00001000 returns 0 with err_o=1.
  - A load of 0x00000000 is unchanged.
- **Abort:** drop mem_ce_i in the first WAIT cycle of a store of 0x55555555 to 0x40.
  - No ack_o; FSM is in IDLE next cycle.
  - A later load of 0x40 returns the old value.
- **Reset mid-op:** assert rst during WAIT of a store.
  - Outputs are 0 next cycle and the store is dropped.
  - Back-to-back loads after reset each take WAIT_CYCLES+1 stall cycles with one IDLE gap.
- **Zero wait:** WAIT_CYCLES=0.
  - Load → ack_o in T+1, stallreq_o high only in T.
  - A store with sel=0000 acks without modifying memory.
